// File: rtl/cntr_pkg.sv
// State encoding for the CLA step counter's last-action FSM.
// Latency: n/a. Backpressure: n/a.
package cntr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        INC  = 2'b10,
        DEC  = 2'b11
    } state_t;

endpackage

// File: rtl/cla_n.sv
// WIDTH-bit adder of GROUP-bit carry-lookahead blocks, carry chained group to group.
// Latency: combinational. Backpressure: none.
module cla_n #(
    parameter int WIDTH = 8,
    parameter int GROUP = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int NG = WIDTH / GROUP;

    if (WIDTH % GROUP != 0) begin : g_bad_group
        $error("cla_n: WIDTH must be a multiple of GROUP");
    end

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;

    assign g = a & b;
    assign p = a ^ b;

    // Each bit carry is a flat generate/propagate sum over its own group,
    // seeded only by the group carry-in.
    always_comb begin
        logic carry;
        logic gcin;
        logic cbit;
        logic cnext;
        logic term;
        s     = '0;
        carry = ci;
        for (int gi = 0; gi < NG; gi++) begin
            gcin = carry;
            cbit = gcin;
            for (int j = 0; j < GROUP; j++) begin
                s[gi*GROUP+j] = p[gi*GROUP+j] ^ cbit;
                cnext = gcin;
                for (int m = 0; m <= j; m++) begin
                    cnext = cnext & p[gi*GROUP+m];
                end
                for (int k = 0; k <= j; k++) begin
                    term = g[gi*GROUP+k];
                    for (int m = k + 1; m <= j; m++) begin
                        term = term & p[gi*GROUP+m];
                    end
                    cnext = cnext | term;
                end
                cbit = cnext;
            end
            carry = cbit;
        end
        co = carry;
    end

endmodule

// File: rtl/cntr_cla_n.sv
// Up/down step counter with load and terminal-count pulse; CNTR_CLA_SAT_EN selects saturation.
// Latency: one clk edge, registered outputs. Backpressure: none, inputs sampled every edge.
module cntr_cla_n
    import cntr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] o,
    output logic             tc,
    output state_t           state
);

    state_t           state_nxt;
    logic [WIDTH-1:0] o_nxt;
    logic             tc_nxt;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] sum;
    logic             co;

    // Subtraction reuses the adder as o + ~step + 1.
    assign add_b = inc ? step : ~step;

    cla_n #(
        .WIDTH(WIDTH),
        .GROUP(GROUP)
    ) u_cla (
        .a (o),
        .b (add_b),
        .ci(~inc),
        .s (sum),
        .co(co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            o     <= '0;
            tc    <= 1'b0;
        end else begin
            state <= state_nxt;
            o     <= o_nxt;
            tc    <= tc_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (load) begin
            state_nxt = LOAD;
        end else if (en && inc) begin
            state_nxt = INC;
        end else if (en) begin
            state_nxt = DEC;
        end
    end

    always_comb begin
        o_nxt  = o;
        tc_nxt = 1'b0;
        unique case (state_nxt)
            LOAD: o_nxt = load_value;
            INC: begin
                o_nxt  = sum;
                tc_nxt = co;
`ifdef CNTR_CLA_SAT_EN
                if (co) o_nxt = '1;
`endif
            end
            DEC: begin
                o_nxt  = sum;
                tc_nxt = ~co;
`ifdef CNTR_CLA_SAT_EN
                if (!co) o_nxt = '0;
`endif
            end
            default: o_nxt = o;
        endcase
    end

endmodule
